// File: rtl/rtc_seconds_counter.sv
// Pokemon Mini RTC seconds counter (0x2008-0x200B): clk_ce prescaler, CPU control
// register, and a host preload handshake that pulses validate_rtc once per preload.
module rtc_seconds_counter #(
    parameter int CE_PER_SECOND = 4000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic        rtc_load_valid,
    input  logic [23:0] rtc_load_seconds,
    output logic        rtc_load_ready,
    output logic        validate_rtc
);

    localparam int PW = $clog2(CE_PER_SECOND);
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(CE_PER_SECOND - 1);

    localparam logic [23:0] ADDR_CTRL = 24'h002008;
    localparam logic [23:0] ADDR_SEC0 = 24'h002009;
    localparam logic [23:0] ADDR_SEC1 = 24'h00200A;
    localparam logic [23:0] ADDR_SEC2 = 24'h00200B;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VALIDATE
    } state_t;

    state_t        state;
    logic [23:0]   seconds;
    logic [23:0]   load_buf;
    logic [PW-1:0] prescaler;
    logic          run;
    logic          write_latch;

    logic ctrl_write;
    logic clear;
    logic load_commit;

    // The CPU strobe is latched on one clk_ce and committed on the next, with the
    // address/data still held on the bus at that second edge.
    assign ctrl_write  = clk_ce && write_latch && (bus_address_in == ADDR_CTRL);
    assign clear       = ctrl_write && bus_data_in[1];
    assign load_commit = clk_ce && (state == LOAD);

    // Control bits 7:2 carry no state.
    logic unused_data_bits;
    assign unused_data_bits = &{1'b0, bus_data_in[7:2]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            seconds        <= '0;
            load_buf       <= '0;
            prescaler      <= '0;
            run            <= 1'b0;
            write_latch    <= 1'b0;
            rtc_load_ready <= 1'b1;
            validate_rtc   <= 1'b0;
        end else begin
            if (clk_ce) begin
                write_latch <= bus_write;
            end

            if (ctrl_write) begin
                run <= bus_data_in[0];
            end

            // Priority: preload commit, then CPU clear, then the prescaler tick.
            if (load_commit) begin
                seconds   <= load_buf;
                prescaler <= '0;
            end else if (clear) begin
                seconds   <= '0;
                prescaler <= '0;
            end else if (clk_ce && run) begin
                if (prescaler == PRESCALE_MAX) begin
                    prescaler <= '0;
                    seconds   <= seconds + 24'd1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // Handshake is accepted on any clk edge, not only clk_ce.
                    if (rtc_load_valid && rtc_load_ready) begin
                        load_buf       <= rtc_load_seconds;
                        rtc_load_ready <= 1'b0;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    if (clk_ce) begin
                        validate_rtc <= 1'b1;
                        state        <= VALIDATE;
                    end
                end
                VALIDATE: begin
                    if (clk_ce) begin
                        validate_rtc   <= 1'b0;
                        rtc_load_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    validate_rtc   <= 1'b0;
                    rtc_load_ready <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        bus_data_out = 8'h00;
        case (bus_address_in)
            ADDR_CTRL: bus_data_out = {7'b0, run};
            ADDR_SEC0: bus_data_out = seconds[7:0];
            ADDR_SEC1: bus_data_out = seconds[15:8];
            ADDR_SEC2: bus_data_out = seconds[23:16];
            default:   bus_data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rtc_seconds_counter.sv
// Directed bench for rtc_seconds_counter with CE_PER_SECOND = 4 and a
// programmable clk_ce divider; expected values are hand-computed.
module tb_rtc_seconds_counter;

    localparam int CE_PER_SECOND = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_ce = 1'b0;
    logic        bus_write = 1'b0;
    logic [23:0] bus_address_in = '0;
    logic [7:0]  bus_data_in = '0;
    logic [7:0]  bus_data_out;
    logic        rtc_load_valid = 1'b0;
    logic [23:0] rtc_load_seconds = '0;
    logic        rtc_load_ready;
    logic        validate_rtc;

    int total = 0;
    int bad = 0;
    int ce_period = 1;
    int ce_cnt = 0;

    rtc_seconds_counter #(.CE_PER_SECOND(CE_PER_SECOND)) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_ce           (clk_ce),
        .bus_write        (bus_write),
        .bus_address_in   (bus_address_in),
        .bus_data_in      (bus_data_in),
        .bus_data_out     (bus_data_out),
        .rtc_load_valid   (rtc_load_valid),
        .rtc_load_seconds (rtc_load_seconds),
        .rtc_load_ready   (rtc_load_ready),
        .validate_rtc     (validate_rtc)
    );

    always #5 clk = ~clk;

    // clk_ce changes on the falling edge so it is stable at every rising edge.
    always @(negedge clk) begin
        ce_cnt = (ce_cnt + 1 >= ce_period) ? 0 : ce_cnt + 1;
        clk_ce = (ce_cnt == 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Returns #1 after the n-th rising edge that has clk_ce high.
    task automatic wait_ce(input int n);
        int seen = 0;
        int budget = n * 8 + 16;
        while (seen < n && budget > 0) begin
            @(posedge clk);
            budget--;
            if (clk_ce) seen++;
        end
        #1;
        if (seen < n) check("wait_ce_timeout", seen, n);
    endtask

    task automatic read_reg(input logic [23:0] addr, output logic [7:0] data);
        bus_address_in = addr;
        #1;
        data = bus_data_out;
    endtask

    task automatic check_seconds(input string tag, input logic [23:0] exp);
        logic [7:0] b0, b1, b2;
        read_reg(24'h002009, b0);
        read_reg(24'h00200A, b1);
        read_reg(24'h00200B, b2);
        check(tag, {8'h00, b2, b1, b0}, {8'h00, exp});
    endtask

    task automatic check_reg(input string tag, input logic [23:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        read_reg(addr, d);
        check(tag, {24'h0, d}, {24'h0, exp});
    endtask

    // Strobe on one clk_ce, commit on the next; returns just after the commit edge.
    task automatic cpu_write(input logic [23:0] addr, input logic [7:0] data);
        bus_address_in = addr;
        bus_data_in    = data;
        bus_write      = 1'b1;
        wait_ce(1);
        bus_write = 1'b0;
        wait_ce(1);
    endtask

    task automatic preload(input logic [23:0] value);
        rtc_load_seconds = value;
        rtc_load_valid   = 1'b1;
        @(posedge clk);
        #1;
        rtc_load_valid = 1'b0;
    endtask

    initial begin
        int found;
        int ce_idx;
        int pulses;
        int pulse_idx;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rtc_load_ready, 1);
        check("rst_validate", validate_rtc, 0);
        check_seconds("rst_seconds", 24'h000000);
        check_reg("rst_ctrl", 24'h002008, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Run: first tick 4 CE after commit, so 19 CE -> 4, 20 CE -> 5
        cpu_write(24'h002008, 8'h01);
        wait_ce(19);
        check_reg("run_19ce", 24'h002009, 8'h04);
        wait_ce(1);
        check_reg("run_20ce", 24'h002009, 8'h05);
        check_reg("run_ctrl", 24'h002008, 8'h01);

        // Preload with carry across bytes
        preload(24'h00FFFE);
        check("pre_ready_low", rtc_load_ready, 0);
        wait_ce(1);
        check("pre_validate", validate_rtc, 1);
        check_seconds("pre_value", 24'h00FFFE);
        wait_ce(7);
        check_seconds("pre_7ce", 24'h00FFFF);
        wait_ce(1);
        check_seconds("pre_8ce", 24'h010000);
        check("pre_ready_back", rtc_load_ready, 1);

        // 24-bit wrap
        preload(24'hFFFFFF);
        wait_ce(1);
        wait_ce(3);
        check_seconds("wrap_before", 24'hFFFFFF);
        wait_ce(1);
        check_seconds("wrap_after", 24'h000000);

        // Handshake on a non-CE edge with clk_ce every 3rd clock, counter stopped
        cpu_write(24'h002008, 8'h00);
        ce_period = 3;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            @(negedge clk);
            #2;
            if (!clk_ce) found = 1;
        end
        check("slow_found_gap", found, 1);
        check("slow_ready_before", rtc_load_ready, 1);
        rtc_load_seconds = 24'h123456;
        rtc_load_valid   = 1'b1;
        @(posedge clk);
        #1;
        rtc_load_valid = 1'b0;
        check("slow_ready_low", rtc_load_ready, 0);
        check("slow_validate_low", validate_rtc, 0);
        ce_idx = 0;
        pulses = 0;
        pulse_idx = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #2;
            if (clk_ce) begin
                ce_idx++;
                if (validate_rtc) begin
                    pulses++;
                    pulse_idx = ce_idx;
                end
            end
        end
        @(posedge clk);
        #1;
        check("slow_pulse_count", pulses, 1);
        check("slow_pulse_ce", pulse_idx, 2);
        check_seconds("slow_value", 24'h123456);
        check("slow_ready_back", rtc_load_ready, 1);
        check("slow_validate_off", validate_rtc, 0);
        ce_period = 1;
        wait_ce(2);

        // Clear committed on the CE where a tick is due
        cpu_write(24'h002008, 8'h01);
        wait_ce(2);
        check_seconds("clr_before", 24'h123456);
        cpu_write(24'h002008, 8'h03);
        check_seconds("clr_zero", 24'h000000);
        check_reg("clr_ctrl", 24'h002008, 8'h01);
        wait_ce(3);
        check_seconds("clr_3ce", 24'h000000);
        wait_ce(1);
        check_seconds("clr_4ce", 24'h000001);

        // Preload commit coincides with a clear that also stops the counter
        bus_address_in   = 24'h002008;
        bus_data_in      = 8'h02;
        bus_write        = 1'b1;
        rtc_load_seconds = 24'hABCDEF;
        rtc_load_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus_write      = 1'b0;
        rtc_load_valid = 1'b0;
        wait_ce(1);
        check_seconds("ld_clr_value", 24'hABCDEF);
        check_reg("ld_clr_run", 24'h002008, 8'h00);
        wait_ce(8);
        check_seconds("ld_clr_held", 24'hABCDEF);

        // Reset while in VALIDATE
        cpu_write(24'h002008, 8'h01);
        preload(24'h000777);
        wait_ce(1);
        check("rv_validate_high", validate_rtc, 1);
        reset = 1'b1;
        #1;
        check("rv_validate_low", validate_rtc, 0);
        check("rv_ready", rtc_load_ready, 1);
        check_seconds("rv_seconds", 24'h000000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (validate_rtc) pulses++;
        end
        @(posedge clk);
        #1;
        check("rv_no_pulse", pulses, 0);
        check("rv_ready_after", rtc_load_ready, 1);

        // Read-only and unmapped addresses
        preload(24'h000042);
        wait_ce(2);
        cpu_write(24'h002009, 8'hAA);
        cpu_write(24'h00200C, 8'hAA);
        check_seconds("ro_unchanged", 24'h000042);
        check_reg("unmapped_2007", 24'h002007, 8'h00);
        check_reg("unmapped_200c", 24'h00200C, 8'h00);
        check_reg("ro_ctrl", 24'h002008, 8'h00);
        cpu_write(24'h002008, 8'hFD);
        check_reg("ctrl_high_bits", 24'h002008, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
